// File: rtl/gb_alu_pkg.sv
// Shared definitions for the gateboy ALU and its sequencer/arbiter (alu_ctrl).
// Contents:
//   aluOpE      - opcode encoding; must stay identical to the ALU's decode
//   Flag*       - bit positions of Z/N/H/C inside the 4-bit flag vector
//   St*         - alu_ctrl state encoding
//   aluReqT     - request fields latched by alu_ctrl at acceptance
//   isLegalOp() - true for opcodes present in aluOpE
package gb_alu_pkg;

  typedef enum logic [4:0] {
    ADD   = 5'd0,
    ADC   = 5'd1,
    SUB   = 5'd2,
    SBC   = 5'd3,
    AND   = 5'd4,
    XOR   = 5'd5,
    OR    = 5'd6,
    CP    = 5'd7,
    RLC   = 5'd8,
    RRC   = 5'd9,
    RL    = 5'd10,
    RR    = 5'd11,
    DAA   = 5'd12,
    CPL   = 5'd13,
    SCF   = 5'd14,
    CCF   = 5'd15,
    SLA   = 5'd16,
    SRA   = 5'd17,
    SRL   = 5'd18,
    SWAP  = 5'd19,
    ADD16 = 5'd20
  } aluOpE;

  localparam int unsigned FlagZ = 3;
  localparam int unsigned FlagN = 2;
  localparam int unsigned FlagH = 1;
  localparam int unsigned FlagC = 0;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StExec = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  typedef struct packed {
    logic [4:0]  op;
    logic [15:0] x;
    logic [15:0] y;
    logic        fwe;
    logic        id;
  } aluReqT;

  function automatic logic isLegalOp(input logic [4:0] op);
    return op <= ADD16;
  endfunction

endpackage

// File: rtl/ALU.sv
// Combinational gateboy ALU.
// Ports:
//   op      in  5  opcode (gb_alu_pkg::aluOpE)
//   x, y    in  16 operands; 8-bit ops use bits [7:0] only
//   fIn     in  4  current flags {Z,N,H,C}
//   o       out 16 result; 8-bit ops return {8'h00, r}
//   fResult out 4  flags produced by the op
// Opcodes outside the enum return o=0 and leave the flags unchanged.
module ALU
  import gb_alu_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [3:0]  fIn,
  output logic [15:0] o,
  output logic [3:0]  fResult
);

  logic [7:0]  a, b, r, adj;
  logic [8:0]  s9;
  logic [16:0] s17;
  logic        z, n, h, c, cin;

  always_comb begin
    a   = x[7:0];
    b   = y[7:0];
    cin = fIn[FlagC];
    r   = a;
    adj = 8'h00;
    s9  = '0;
    s17 = '0;
    z   = fIn[FlagZ];
    n   = fIn[FlagN];
    h   = fIn[FlagH];
    c   = fIn[FlagC];

    case (op)
      ADD, ADC: begin
        s9 = {1'b0, a} + {1'b0, b} + {8'h00, (op == ADC) & cin};
        r  = s9[7:0];
        z  = (r == 8'h00);
        n  = 1'b0;
        h  = a[4] ^ b[4] ^ s9[4];  // carry into bit 4
        c  = s9[8];
      end
      SUB, SBC, CP: begin
        s9 = {1'b0, a} - {1'b0, b} - {8'h00, (op == SBC) & cin};
        r  = (op == CP) ? a : s9[7:0];
        z  = (s9[7:0] == 8'h00);
        n  = 1'b1;
        h  = a[4] ^ b[4] ^ s9[4];  // borrow into bit 4
        c  = s9[8];
      end
      AND: begin
        r = a & b; z = (r == 8'h00); n = 1'b0; h = 1'b1; c = 1'b0;
      end
      XOR: begin
        r = a ^ b; z = (r == 8'h00); n = 1'b0; h = 1'b0; c = 1'b0;
      end
      OR: begin
        r = a | b; z = (r == 8'h00); n = 1'b0; h = 1'b0; c = 1'b0;
      end
      RLC: begin
        r = {a[6:0], a[7]}; z = (r == 8'h00); n = 1'b0; h = 1'b0; c = a[7];
      end
      RRC: begin
        r = {a[0], a[7:1]}; z = (r == 8'h00); n = 1'b0; h = 1'b0; c = a[0];
      end
      RL: begin
        r = {a[6:0], cin}; z = (r == 8'h00); n = 1'b0; h = 1'b0; c = a[7];
      end
      RR: begin
        r = {cin, a[7:1]}; z = (r == 8'h00); n = 1'b0; h = 1'b0; c = a[0];
      end
      DAA: begin
        if (!fIn[FlagN]) begin
          if (fIn[FlagC] || (a > 8'h99)) begin
            adj = adj | 8'h60;
            c   = 1'b1;
          end
          if (fIn[FlagH] || (a[3:0] > 4'h9)) adj = adj | 8'h06;
          r = a + adj;
        end else begin
          if (fIn[FlagC]) adj = adj | 8'h60;
          if (fIn[FlagH]) adj = adj | 8'h06;
          r = a - adj;
        end
        z = (r == 8'h00);
        h = 1'b0;
      end
      CPL: begin
        r = ~a; n = 1'b1; h = 1'b1;
      end
      SCF: begin
        n = 1'b0; h = 1'b0; c = 1'b1;
      end
      CCF: begin
        n = 1'b0; h = 1'b0; c = ~fIn[FlagC];
      end
      SLA: begin
        r = {a[6:0], 1'b0}; z = (r == 8'h00); n = 1'b0; h = 1'b0; c = a[7];
      end
      SRA: begin
        r = {a[7], a[7:1]}; z = (r == 8'h00); n = 1'b0; h = 1'b0; c = a[0];
      end
      SRL: begin
        r = {1'b0, a[7:1]}; z = (r == 8'h00); n = 1'b0; h = 1'b0; c = a[0];
      end
      SWAP: begin
        r = {a[3:0], a[7:4]}; z = (r == 8'h00); n = 1'b0; h = 1'b0; c = 1'b0;
      end
      ADD16: begin
        s17 = {1'b0, x} + {1'b0, y};
        n   = 1'b0;
        h   = x[12] ^ y[12] ^ s17[12];  // carry out of bit 11
        c   = s17[16];
      end
      default: ;
    endcase

    if (op == ADD16) begin
      o = s17[15:0];
    end else if (op > ADD16) begin
      o = 16'h0000;
    end else begin
      o = {8'h00, r};
    end

    fResult        = 4'b0000;
    fResult[FlagZ] = z;
    fResult[FlagN] = n;
    fResult[FlagH] = h;
    fResult[FlagC] = c;
  end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
// Ports:
//   clk, reset in  1 clock, synchronous active-high reset
//   req        in  2 request per requester
//   accept     in  1 the current grant was taken; advances the pointer
//   grant      out 2 one-hot (or zero) grant
// Parameter RR_INIT selects which requester has priority after reset.
module rr_arb2 #(
  parameter int unsigned RR_INIT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  // prioQ names the requester that wins a simultaneous contest.
  logic prioQ;

  always_comb begin
    grant = 2'b00;
    if (prioQ) begin
      if (req[1])      grant = 2'b10;
      else if (req[0]) grant = 2'b01;
    end else begin
      if (req[0])      grant = 2'b01;
      else if (req[1]) grant = 2'b10;
    end
  end

  // The loser of the accepted grant gets priority next time.
  always_ff @(posedge clk) begin
    if (reset) begin
      prioQ <= (RR_INIT != 0);
    end else if (accept) begin
      prioQ <= grant[0];
    end
  end

endmodule

// File: rtl/alu_ctrl.sv
// Sequencer/arbiter sharing the ALU between the execute unit (requester 0) and the
// address/stack-adjust unit (requester 1); owns the flag register F.
// Ports:
//   clk, reset            in  system clock, synchronous active-high reset
//   req_valid/req_ready   2   per-requester request handshake
//   req_op/x/y/fwe        per-requester opcode, operands, F write enable
//   rsp_valid/rsp_ready   response handshake
//   rsp_id, rsp_o, rsp_f  response owner, ALU result, ALU flag result
//   rsp_err               illegal opcode flag (0 unless ALU_CTRL_ILLEGAL_EN)
//   f_out                 current F {Z,N,H,C}
//   f_load, f_load_val    direct F load (POP AF); beats a same-cycle completion write
// Build option: define ALU_CTRL_ILLEGAL_EN to reject opcodes 21..31 with rsp_err=1.
module alu_ctrl
  import gb_alu_pkg::*;
#(
  parameter int unsigned RR_INIT = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [1:0][4:0] req_op,
  input  logic [1:0][15:0] req_x,
  input  logic [1:0][15:0] req_y,
  input  logic [1:0]      req_fwe,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [15:0]     rsp_o,
  output logic [3:0]      rsp_f,
  output logic            rsp_err,
  output logic [3:0]      f_out,
  input  logic            f_load,
  input  logic [3:0]      f_load_val
);

  logic [1:0]  stateQ, stateD;
  aluReqT      latQ, latD;
  logic [1:0]  grant;
  logic        accept;
  logic        winner;
  logic [15:0] rspOQ;
  logic [3:0]  rspFQ;
  logic        rspErrQ;
  logic [3:0]  fQ;
  logic [15:0] aluO;
  logic [3:0]  aluF;
  logic        illegal;

  rr_arb2 #(
    .RR_INIT(RR_INIT)
  ) uArb (
    .clk   (clk),
    .reset (reset),
    .req   (req_valid),
    .accept(accept),
    .grant (grant)
  );

  assign req_ready = ((stateQ == StIdle) && !reset) ? grant : 2'b00;
  assign accept    = |(req_valid & req_ready);
  assign winner    = grant[1];

  always_comb begin
    latD.op  = req_op[winner];
    latD.x   = req_x[winner];
    latD.y   = req_y[winner];
    latD.fwe = req_fwe[winner];
    latD.id  = winner;
  end

  ALU uAlu (
    .op     (latQ.op),
    .x      (latQ.x),
    .y      (latQ.y),
    .fIn    (fQ),
    .o      (aluO),
    .fResult(aluF)
  );

`ifdef ALU_CTRL_ILLEGAL_EN
  assign illegal = !isLegalOp(latQ.op);
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      StIdle:  if (accept) stateD = StExec;
      StExec:  stateD = StResp;
      StResp:  if (rsp_ready) stateD = StIdle;
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ  <= StIdle;
      latQ    <= '0;
      rspOQ   <= 16'h0000;
      rspFQ   <= 4'b0000;
      rspErrQ <= 1'b0;
      fQ      <= 4'b0000;
    end else begin
      stateQ <= stateD;
      if (accept) latQ <= latD;
      if (stateQ == StExec) begin
        rspOQ   <= illegal ? 16'h0000 : aluO;
        rspFQ   <= illegal ? 4'b0000 : aluF;
        rspErrQ <= illegal;
      end
      // A direct load overrides the completion write; rsp_f still carries aluF.
      if (f_load) begin
        fQ <= f_load_val;
      end else if ((stateQ == StExec) && latQ.fwe && !illegal) begin
        fQ <= aluF;
      end
    end
  end

  assign rsp_valid = (stateQ == StResp);
  assign rsp_id    = latQ.id;
  assign rsp_o     = rspOQ;
  assign rsp_f     = rspFQ;
  assign rsp_err   = rspErrQ;
  assign f_out     = fQ;

endmodule

// File: tb/tb_alu_ctrl.sv
module tb_alu_ctrl;
  import gb_alu_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][4:0]  req_op;
  logic [1:0][15:0] req_x;
  logic [1:0][15:0] req_y;
  logic [1:0]       req_fwe;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [15:0]      rsp_o;
  logic [3:0]       rsp_f;
  logic             rsp_err;
  logic [3:0]       f_out;
  logic             f_load;
  logic [3:0]       f_load_val;

  typedef struct packed {
    logic        id;
    logic [15:0] o;
    logic [3:0]  f;
    logic        err;
  } expT;

  expT sb[$];
  int  total = 0;
  int  bad   = 0;

  alu_ctrl #(
    .RR_INIT(0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_fwe   (req_fwe),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_o     (rsp_o),
    .rsp_f     (rsp_f),
    .rsp_err   (rsp_err),
    .f_out     (f_out),
    .f_load    (f_load),
    .f_load_val(f_load_val)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pushExp(input logic id, input logic [15:0] o, input logic [3:0] f,
                         input logic err);
    expT e;
    e.id = id; e.o = o; e.f = f; e.err = err;
    sb.push_back(e);
  endtask

  task automatic popChk(input string tag);
    expT e;
    chk({tag, "_sbNonEmpty"}, (sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_id"}, rsp_id, e.id);
      chk({tag, "_o"}, rsp_o, e.o);
      chk({tag, "_f"}, rsp_f, e.f);
      chk({tag, "_err"}, rsp_err, e.err);
    end
  endtask

  // One full transaction; called at negedge+1 with the DUT idle.
  task automatic doOp(input string tag, input logic id, input logic [4:0] op,
                      input logic [15:0] x, input logic [15:0] y, input logic fwe,
                      input logic [15:0] expO, input logic [3:0] expF, input logic expErr,
                      input int hold, input logic fLd, input logic [3:0] fLdVal);
    int n;
    req_op[id]  = op;
    req_x[id]   = x;
    req_y[id]   = y;
    req_fwe[id] = fwe;
    req_valid   = id ? 2'b10 : 2'b01;
    rsp_ready   = 1'b0;
    #1;
    chk({tag, "_reqReady"}, req_ready, id ? 2'b10 : 2'b01);
    @(posedge clk);
    pushExp(id, expO, expF, expErr);
    @(negedge clk); #1;
    req_valid = 2'b00;
    if (fLd) begin
      f_load     = 1'b1;
      f_load_val = fLdVal;
    end
    chk({tag, "_execNoValid"}, rsp_valid, 0);
    chk({tag, "_execNoReady"}, req_ready, 2'b00);
    @(negedge clk); #1;
    f_load = 1'b0;
    n = 2;
    while (!rsp_valid && n < 12) begin
      @(negedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, n, 2);
    if (hold > 0) req_valid = 2'b11;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk); #1;
      chk({tag, "_holdValid"}, rsp_valid, 1);
      chk({tag, "_holdReady"}, req_ready, 2'b00);
      chk({tag, "_holdO"}, rsp_o, expO);
      chk({tag, "_holdF"}, rsp_f, expF);
    end
    popChk(tag);
    rsp_ready = 1'b1;
    req_valid = 2'b00;
    @(negedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, "_backIdle"}, rsp_valid, 0);
  endtask

  initial begin
    int lastCyc;
    int nGrant;
    logic expId;

    reset      = 1'b1;
    req_valid  = 2'b11;
    req_op     = '0;
    req_x      = '0;
    req_y      = '0;
    req_fwe    = 2'b00;
    rsp_ready  = 1'b0;
    f_load     = 1'b0;
    f_load_val = 4'b0000;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_reqReady", req_ready, 2'b00);
    chk("rst_rspValid", rsp_valid, 0);
    chk("rst_rspO", rsp_o, 16'h0000);
    chk("rst_rspF", rsp_f, 4'b0000);
    chk("rst_rspId", rsp_id, 0);
    chk("rst_rspErr", rsp_err, 0);
    chk("rst_fOut", f_out, 4'b0000);

    // Both requesters valid every cycle: grants must alternate 0,1,0,1 three cycles apart.
    req_op[0] = ADD; req_x[0] = 16'h0001; req_y[0] = 16'h0002; req_fwe[0] = 1'b0;
    req_op[1] = SUB; req_x[1] = 16'h0005; req_y[1] = 16'h0003; req_fwe[1] = 1'b0;
    rsp_ready = 1'b1;
    reset     = 1'b0;
    #1;
    lastCyc = -1;
    nGrant  = 0;
    expId   = 1'b0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (cyc > 0) begin
        @(negedge clk); #1;
      end
      if (rsp_valid) popChk("alt");
      if (req_ready != 2'b00) begin
        chk("alt_grant", req_ready, expId ? 2'b10 : 2'b01);
        if (lastCyc >= 0) chk("alt_gap", cyc - lastCyc, 3);
        if (req_ready[1]) pushExp(1'b1, 16'h0002, 4'b0100, 1'b0);
        else              pushExp(1'b0, 16'h0003, 4'b0000, 1'b0);
        lastCyc = cyc;
        expId   = ~expId;
        nGrant++;
      end
    end
    @(negedge clk); #1;
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    chk("alt_grants", nGrant, 4);
    chk("alt_drained", sb.size(), 0);
    chk("alt_fOut", f_out, 4'b0000);

    // 0x3A + 0xC6 = 0x100: zero, half carry, carry
    doOp("add8", 1'b0, ADD, 16'h003A, 16'h00C6, 1'b1, 16'h0000, 4'b1011, 1'b0, 0, 1'b0, 4'h0);
    chk("add8_fOut", f_out, 4'b1011);

    // Direct load of F while idle
    f_load = 1'b1; f_load_val = 4'b0000;
    @(negedge clk); #1;
    f_load = 1'b0;
    chk("fload_idle", f_out, 4'b0000);

    // SUB to zero without F write, response stalled five cycles
    doOp("subStall", 1'b1, SUB, 16'h003E, 16'h003E, 1'b0, 16'h0000, 4'b1100, 1'b0, 5, 1'b0,
         4'h0);
    chk("subStall_fOut", f_out, 4'b0000);

    // 8-bit op ignores upper operand bytes
    doOp("hiByte", 1'b0, ADD, 16'h1234, 16'h0001, 1'b0, 16'h0035, 4'b0000, 1'b0, 0, 1'b0, 4'h0);

    // CP keeps x, 0x42-0x50 borrows out of bit 7 only
    doOp("cp", 1'b1, CP, 16'h0042, 16'h0050, 1'b0, 16'h0042, 4'b0101, 1'b0, 0, 1'b0, 4'h0);

    doOp("and", 1'b0, AND, 16'h00F0, 16'h000F, 1'b0, 16'h0000, 4'b1010, 1'b0, 0, 1'b0, 4'h0);

    // f_load coinciding with a completion write: load wins, rsp_f still FResult
    doOp("floadExec", 1'b0, ADD, 16'h000F, 16'h0001, 1'b1, 16'h0010, 4'b0010, 1'b0, 0, 1'b1,
         4'b0101);
    chk("floadExec_fOut", f_out, 4'b0101);

    // Reset during EXEC of ADD16 drops the op
    req_op[1] = ADD16; req_x[1] = 16'h8800; req_y[1] = 16'h8800; req_fwe[1] = 1'b1;
    req_valid = 2'b10;
    #1;
    chk("rstExec_reqReady", req_ready, 2'b10);
    @(posedge clk);
    @(negedge clk); #1;
    req_valid = 2'b11;
    reset     = 1'b1;
    chk("rstExec_inReset_ready", req_ready, 2'b00);
    @(negedge clk); #1;
    chk("rstExec_rspValid", rsp_valid, 0);
    chk("rstExec_fOut", f_out, 4'b0000);
    chk("rstExec_rspO", rsp_o, 16'h0000);
    chk("rstExec_rspF", rsp_f, 4'b0000);
    chk("rstExec_rspId", rsp_id, 0);
    chk("rstExec_reqReady", req_ready, 2'b00);
    reset     = 1'b0;
    req_valid = 2'b00;
    @(negedge clk); #1;
    chk("rstExec_after", rsp_valid, 0);

    // ADD16 uses all 16 bits; Z untouched, carries out of bits 11 and 15
    doOp("add16", 1'b0, ADD16, 16'h8800, 16'h8800, 1'b1, 16'h1000, 4'b0011, 1'b0, 0, 1'b0,
         4'h0);
    chk("add16_fOut", f_out, 4'b0011);

`ifdef ALU_CTRL_ILLEGAL_EN
    doOp("illegal", 1'b0, 5'd25, 16'h1234, 16'h5678, 1'b1, 16'h0000, 4'b0000, 1'b1, 0, 1'b0,
         4'h0);
    chk("illegal_fOut", f_out, 4'b0011);
`endif

    chk("final_sbEmpty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_ctrl.md
# alu_ctrl

Sequencer and arbiter in front of the combinational `ALU` in `gateboy/cpu`. It shares the ALU between two requesters: requester 0 is the execute unit and requester 1 is the address/stack-adjust unit. It also owns the architectural flag register F. Each request is accepted through a valid/ready handshake, registered into the ALU, and its result is captured and returned through a second valid/ready handshake. F is updated on completion.

## Interface
Parameters:
- `RR_INIT`, default 0: requester that wins the first simultaneous contest after reset.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: one clock; reset is synchronous and active-high.
- `req_valid` in 2: request valid, one bit per requester.
- `req_ready` out 2: request accepted when `req_valid[i] & req_ready[i]`.
- `req_op` in 2x5: ALU opcode per requester.
- `req_x` in 2x16: first operand per requester.
- `req_y` in 2x16: second operand per requester.
- `req_fwe` in 2: write FResult into F on completion.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response consumed when `rsp_valid & rsp_ready`.
- `rsp_id` out 1: requester that owns the response.
- `rsp_o` out 16: ALU result O.
- `rsp_f` out 4: ALU FResult.
- `rsp_err` out 1: illegal opcode (only with the macro in Configuration).
- `f_out` out 4: current F, bit order {Z,N,H,C}.
- `f_load` in 1: load F directly (POP AF).
- `f_load_val` in 4: value for `f_load`.

## Operation
- State machine with three states: IDLE, EXEC, RESP.
- IDLE:
  - `req_ready[i]` is high only for the arbitration winner. At most one bit of `req_ready` is high.
  - Arbitration is round-robin: the requester that did not win last has priority. `RR_INIT` sets the initial priority.
  - On handshake: latch op, x, y, fwe and id, then go to EXEC.
- EXEC, exactly one cycle:
  - ALU sees the latched op, x, y and the current F.
  - At the clock edge, O and FResult are captured into the response registers. If fwe is set, F ← FResult.
  - Go to RESP.
- RESP:
  - `rsp_valid`=1; response fields are held stable until the handshake.
  - On `rsp_ready`, go to IDLE.
  - `req_ready` is 0 in EXEC and RESP.
- `f_load` is honoured in any state. If it coincides with an EXEC completion write, `f_load` wins and FResult is still reported on `rsp_f`.
- Width rules:
  - 8-bit ops use x[7:0] and y[7:0]; the ALU output passes through unmodified.
  - ADD16 uses the full 16 bits.
  - The controller performs no sign or zero extension.
- F is not fed forward: a request latched in the same edge as a completion sees the updated F, because EXEC always follows latching.

## Timing
- Reset values:
  - State IDLE.
  - `rsp_valid`=0.
  - `rsp_o`=0, `rsp_f`=0, `rsp_id`=0, `rsp_err`=0.
  - F=0000.
  - `req_ready`=0 during reset, then the arbitration result in IDLE.
- Latency: handshake at edge N → `rsp_valid` high in the cycle after edge N+1 (two edges).
- Throughput: one op per three cycles with `rsp_ready` held at 1.
- The arbiter pointer updates only on an accepted handshake.
- Reset during EXEC or RESP: in-flight op dropped, F not written, outputs return to reset values.

## Configuration
- `ALU_CTRL_ILLEGAL_EN` defined:
  - Opcodes not in the package enum (21..31) skip the ALU.
  - The response is returned with `rsp_err`=1 and `rsp_o`=0.
  - F is never written for these opcodes.
  - Latency is unchanged.
- Undefined:
  - `rsp_err` is tied to 0.
  - Every opcode is passed to the ALU unchecked.

## Structure
- Package `gb_alu_pkg`:
  - Opcode constants ADD=0, ADC=1, SUB=2, SBC=3, AND=4, XOR=5, OR=6, CP=7, RLC=8, RRC=9, RL=10, RR=11, DAA=12, CPL=13, SCF=14, CCF=15, SLA=16, SRA=17, SRL=18, SWAP=19, ADD16=20. These must match the ALU's localparams.
  - Flag bit indices Z=3, N=2, H=1, C=0.
  - State encoding.
- Sub-module `rr_arb2`: two-way round-robin arbiter with grant and pointer update.
- Existing `ALU` is instantiated unchanged.

## Test plan
- Req0 ADD x=0x003A y=0x00C6 fwe=1, F=0 → `rsp_o`=0x0000, `rsp_f`=1011, `f_out`=1011; `rsp_valid` high 2 edges after the handshake.
- Both requesters valid every cycle, `rsp_ready`=1, `RR_INIT`=0 → grants alternate 0,1,0,1; each grant 3 cycles apart.
- Req1 SUB x=0x3E y=0x3E fwe=0, F=0000 → `rsp_f`=1100 and `f_out` stays 0000.
- `rsp_ready` low for 5 cycles in RESP → fields stable, `req_ready`=00 throughout; handshake on the 6th cycle → IDLE next.
- `f_load` with value 0101 in the same cycle as an EXEC with fwe=1 → `f_out`=0101.
- Reset asserted during EXEC of ADD16 → no F write, `rsp_valid`=0. With `ALU_CTRL_ILLEGAL_EN`, op 25 → `rsp_err`=1, `rsp_o`=0, F unchanged.
